// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: byte-addressed data memory, branch flag, MEM/WB pass-through
// Build option MEM_SIGN_EXTEND_EN: byte/halfword loads sign-extend instead of zero-extend.
module mem_stage #(
    parameter int NB_ADDR   = 32,
    parameter int NB_DATA   = 32,
    parameter int NB_PC     = 32,
    parameter int NB_REG    = 5,
    parameter int MEM_DEPTH = 256
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_MEM_reg_write,
    input  logic               i_MEM_mem_to_reg,
    input  logic               i_MEM_mem_read,
    input  logic               i_MEM_mem_write,
    input  logic               i_MEM_word_enable,
    input  logic               i_MEM_halfword_enable,
    input  logic               i_MEM_byte_enable,
    input  logic               i_MEM_branch,
    input  logic               i_MEM_zero,
    input  logic [NB_PC-1:0]   i_MEM_branch_addr,
    input  logic [NB_ADDR-1:0] i_MEM_alu_result,
    input  logic [NB_DATA-1:0] i_MEM_write_data,
    input  logic [NB_REG-1:0]  i_MEM_selected_reg,
    input  logic               i_MEM_last_register_ctrl,
    input  logic [NB_PC-1:0]   i_MEM_pc,
    output logic [NB_DATA-1:0] o_MEM_mem_data,
    output logic [NB_REG-1:0]  o_MEM_selected_reg,
    output logic [NB_ADDR-1:0] o_MEM_alu_result,
    output logic [NB_PC-1:0]   o_MEM_branch_addr,
    output logic               o_MEM_reg_write,
    output logic               o_MEM_mem_to_reg,
    output logic               o_MEM_last_register_ctrl,
    output logic [NB_PC-1:0]   o_MEM_pc,
    output logic               o_MEM_branch_zero
);

    localparam int NB_IDX = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

`ifdef MEM_SIGN_EXTEND_EN
    localparam logic SIGN_EXT = 1'b1;
`else
    localparam logic SIGN_EXT = 1'b0;
`endif

    logic [7:0]         mem [MEM_DEPTH];
    logic [NB_ADDR-1:0] base;
    logic [NB_IDX-1:0]  idx [4];
    logic [7:0]         lane [4];
    logic [2:0]         store_bytes;

    // Reduce the address first so base + k cannot overflow before the wrap.
    assign base = i_MEM_alu_result % NB_ADDR'(MEM_DEPTH);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx[k]  = NB_IDX'((base + NB_ADDR'(k)) % NB_ADDR'(MEM_DEPTH));
            lane[k] = mem[idx[k]];
        end
    end

    always_comb begin
        store_bytes = 3'd0;
        if (i_MEM_word_enable)
            store_bytes = 3'd4;
        else if (i_MEM_halfword_enable)
            store_bytes = 3'd2;
        else if (i_MEM_byte_enable)
            store_bytes = 3'd1;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < MEM_DEPTH; i++)
                mem[i] <= 8'h00;
        end else if (i_MEM_mem_write) begin
            for (int k = 0; k < 4; k++)
                if (k < int'(store_bytes))
                    mem[idx[k]] <= i_MEM_write_data[8*k +: 8];
        end
    end

    // A load with no size selected returns the full word.
    always_comb begin
        o_MEM_mem_data = '0;
        if (i_reset_n && i_MEM_mem_read) begin
            if (i_MEM_word_enable || !(i_MEM_halfword_enable || i_MEM_byte_enable))
                o_MEM_mem_data = NB_DATA'({lane[3], lane[2], lane[1], lane[0]});
            else if (i_MEM_halfword_enable)
                o_MEM_mem_data = {{(NB_DATA-16){SIGN_EXT & lane[1][7]}}, lane[1], lane[0]};
            else
                o_MEM_mem_data = {{(NB_DATA-8){SIGN_EXT & lane[0][7]}}, lane[0]};
        end
    end

    assign o_MEM_selected_reg       = i_MEM_selected_reg;
    assign o_MEM_alu_result         = i_MEM_alu_result;
    assign o_MEM_branch_addr        = i_MEM_branch_addr;
    assign o_MEM_reg_write          = i_MEM_reg_write;
    assign o_MEM_mem_to_reg         = i_MEM_mem_to_reg;
    assign o_MEM_last_register_ctrl = i_MEM_last_register_ctrl;
    assign o_MEM_pc                 = i_MEM_pc;
    assign o_MEM_branch_zero        = i_MEM_branch & i_MEM_zero;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against a byte-array model
module tb_mem_stage;

    localparam int DEPTH = 256;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        reg_write = 0, mem_to_reg = 0, mem_read = 0, mem_write = 0;
    logic        word_en = 0, half_en = 0, byte_en = 0, branch = 0, zero = 0, last_ctrl = 0;
    logic [31:0] branch_addr = 0, alu_result = 0, write_data = 0, pc = 0;
    logic [4:0]  selected_reg = 0;
    logic [31:0] o_mem_data, o_alu_result, o_branch_addr, o_pc;
    logic [4:0]  o_selected_reg;
    logic        o_reg_write, o_mem_to_reg, o_last_ctrl, o_branch_zero;

    logic [7:0]  model_mem [DEPTH];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] got, exp;

    mem_stage #(.NB_ADDR(32), .NB_DATA(32), .NB_PC(32), .NB_REG(5), .MEM_DEPTH(DEPTH)) dut (
        .i_clock(clock), .i_reset_n(reset_n),
        .i_MEM_reg_write(reg_write), .i_MEM_mem_to_reg(mem_to_reg),
        .i_MEM_mem_read(mem_read), .i_MEM_mem_write(mem_write),
        .i_MEM_word_enable(word_en), .i_MEM_halfword_enable(half_en), .i_MEM_byte_enable(byte_en),
        .i_MEM_branch(branch), .i_MEM_zero(zero), .i_MEM_branch_addr(branch_addr),
        .i_MEM_alu_result(alu_result), .i_MEM_write_data(write_data),
        .i_MEM_selected_reg(selected_reg), .i_MEM_last_register_ctrl(last_ctrl), .i_MEM_pc(pc),
        .o_MEM_mem_data(o_mem_data), .o_MEM_selected_reg(o_selected_reg),
        .o_MEM_alu_result(o_alu_result), .o_MEM_branch_addr(o_branch_addr),
        .o_MEM_reg_write(o_reg_write), .o_MEM_mem_to_reg(o_mem_to_reg),
        .o_MEM_last_register_ctrl(o_last_ctrl), .o_MEM_pc(o_pc), .o_MEM_branch_zero(o_branch_zero)
    );

    always #5 clock = ~clock;

    function automatic int wrap_idx(input logic [31:0] a, input int k);
        return int'((longint'(a) + k) % DEPTH);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic rd,
                                               input logic w, input logic h, input logic b);
        int n;
        logic [31:0] v;
        v = 32'h0;
        if (!rd) return v;
        n = w ? 4 : h ? 2 : b ? 1 : 4;
        for (int k = 0; k < n; k++)
            v = v | (32'(model_mem[wrap_idx(a, k)]) << (8*k));
`ifdef MEM_SIGN_EXTEND_EN
        if (n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
`endif
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d,
                               input logic w, input logic h, input logic b);
        int n;
        n = w ? 4 : h ? 2 : b ? 1 : 0;
        for (int k = 0; k < n; k++)
            model_mem[wrap_idx(a, k)] = d[8*k +: 8];
    endtask

    function automatic logic [102:0] side_exp();
        return {reg_write, mem_to_reg, last_ctrl, selected_reg, alu_result, branch_addr, pc,
                branch & zero};
    endfunction

    function automatic logic [102:0] side_got();
        return {o_reg_write, o_mem_to_reg, o_last_ctrl, o_selected_reg, o_alu_result,
                o_branch_addr, o_pc, o_branch_zero};
    endfunction

    // One clock of traffic: load observed before the edge, store committed at the edge.
    task automatic access(input logic rd, input logic wr, input logic w, input logic h,
                          input logic b, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] g, output logic [31:0] e);
        @(negedge clock);
        mem_read = rd; mem_write = wr; word_en = w; half_en = h; byte_en = b;
        alu_result = a; write_data = d;
        #1;
        g = o_mem_data;
        e = model_load(a, rd, w, h, b);
        @(posedge clock);
        if (wr && reset_n) model_store(a, d, w, h, b);
        #1;
        mem_write = 1'b0;
        mem_read  = 1'b0;
    endtask

    task automatic test_reset();
        mem_read = 1; word_en = 1; alu_result = 0; mem_write = 1; write_data = 32'hFFFF_FFFF;
        #1;
        n_cmp++;
        if (o_mem_data !== 32'h0) begin
            n_err++; $display("FAIL reset_data got=%h exp=%h", o_mem_data, 32'h0);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        mem_write = 0;
        reset_n = 1;
        access(1, 0, 1, 0, 0, 32'h0, 32'h0, got, exp);
        n_cmp++;
        if (got !== 32'h0) begin
            n_err++; $display("FAIL reset_word0 got=%h exp=%h", got, 32'h0);
        end
    endtask

    task automatic test_spec_sequence();
        access(0, 1, 0, 0, 1, 32'd10, 32'd14, got, exp);
        access(0, 1, 1, 0, 0, 32'd0, 32'd257, got, exp);
        access(1, 0, 1, 0, 0, 32'd0, 32'h0, got, exp);
        n_cmp++;
        if (got !== 32'h0000_0101) begin
            n_err++; $display("FAIL word_at_0 got=%h exp=%h", got, 32'h0000_0101);
        end
        access(1, 0, 0, 0, 1, 32'd10, 32'h0, got, exp);
        n_cmp++;
        if (got !== 32'h0000_000E) begin
            n_err++; $display("FAIL byte_at_10 got=%h exp=%h", got, 32'h0000_000E);
        end
        access(1, 0, 0, 1, 0, 32'd3, 32'h0, got, exp);
        n_cmp++;
        if (got !== 32'h0) begin
            n_err++; $display("FAIL half_at_3 got=%h exp=%h", got, 32'h0);
        end
        access(1, 0, 0, 1, 0, 32'd0, 32'h0, got, exp);
        n_cmp++;
        if (got !== 32'h0000_0101) begin
            n_err++; $display("FAIL half_at_0 got=%h exp=%h", got, 32'h0000_0101);
        end
        access(0, 0, 1, 0, 0, 32'd0, 32'h0, got, exp);
        n_cmp++;
        if (got !== 32'h0) begin
            n_err++; $display("FAIL read_disabled got=%h exp=%h", got, 32'h0);
        end
    endtask

    task automatic test_branch();
        @(negedge clock);
        branch = 0; zero = 1; branch_addr = 32'h0;
        #1;
        n_cmp++;
        if (o_branch_zero !== 1'b0) begin
            n_err++; $display("FAIL branch_not_taken got=%b exp=0", o_branch_zero);
        end
        branch = 1; zero = 1; branch_addr = 32'hF;
        #1;
        n_cmp++;
        if (o_branch_zero !== 1'b1 || o_branch_addr !== 32'hF) begin
            n_err++; $display("FAIL branch_taken got=%b/%h exp=1/0000000f", o_branch_zero, o_branch_addr);
        end
        branch = 0; zero = 0;
    endtask

    task automatic test_sign();
        logic [31:0] want;
`ifdef MEM_SIGN_EXTEND_EN
        want = 32'hFFFF_FFF0;
`else
        want = 32'h0000_00F0;
`endif
        access(0, 1, 0, 0, 1, 32'd5, 32'h0000_00F0, got, exp);
        access(1, 0, 0, 0, 1, 32'd5, 32'h0, got, exp);
        n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL byte_ext_at_5 got=%h exp=%h", got, want);
        end
    endtask

    task automatic test_wrap();
        access(0, 1, 1, 0, 0, 32'(DEPTH-2), 32'hAABB_CCDD, got, exp);
        access(1, 0, 0, 0, 1, 32'd0, 32'h0, got, exp);
        n_cmp++;
        if (got !== 32'h0000_00BB) begin
            n_err++; $display("FAIL wrap_byte0 got=%h exp=%h", got, 32'h0000_00BB);
        end
        access(1, 0, 0, 0, 1, 32'(DEPTH-2), 32'h0, got, exp);
        n_cmp++;
        if (got !== 32'h0000_00DD) begin
            n_err++; $display("FAIL wrap_byte_top got=%h exp=%h", got, 32'h0000_00DD);
        end
        access(1, 0, 1, 0, 0, 32'(DEPTH-2), 32'h0, got, exp);
        n_cmp++;
        if (got !== 32'hAABB_CCDD) begin
            n_err++; $display("FAIL wrap_word got=%h exp=%h", got, 32'hAABB_CCDD);
        end
    endtask

    task automatic test_read_during_write();
        access(1, 1, 1, 0, 0, 32'd40, 32'h1234_5678, got, exp);
        n_cmp++;
        if (got !== 32'h0) begin
            n_err++; $display("FAIL rdw_old got=%h exp=%h", got, 32'h0);
        end
        access(1, 0, 1, 0, 0, 32'd40, 32'h0, got, exp);
        n_cmp++;
        if (got !== 32'h1234_5678) begin
            n_err++; $display("FAIL rdw_new got=%h exp=%h", got, 32'h1234_5678);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        mem_read = 1; word_en = 1; half_en = 0; byte_en = 0; alu_result = 32'd40;
        #2;
        reset_n = 0;
        #1;
        n_cmp++;
        if (o_mem_data !== 32'h0) begin
            n_err++; $display("FAIL async_reset_data got=%h exp=%h", o_mem_data, 32'h0);
        end
        branch = 1; zero = 1; pc = 32'hDEAD_BEEF; selected_reg = 5'd17;
        #1;
        n_cmp++;
        if (side_got() !== side_exp()) begin
            n_err++; $display("FAIL reset_passthru got=%h exp=%h", side_got(), side_exp());
        end
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        @(negedge clock);
        reset_n = 1;
        access(1, 0, 1, 0, 0, 32'd40, 32'h0, got, exp);
        n_cmp++;
        if (got !== 32'h0) begin
            n_err++; $display("FAIL async_reset_cleared got=%h exp=%h", got, 32'h0);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int it = 0; it < 400; it++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0)
                a = (a & 32'hFFFF_FF00) | ($urandom_range(0, 1) ? 32'($urandom_range(0, 15))
                                                               : 32'($urandom_range(DEPTH-6, DEPTH-1)));
            reg_write = 1'($urandom); mem_to_reg = 1'($urandom); last_ctrl = 1'($urandom);
            branch = 1'($urandom); zero = 1'($urandom); selected_reg = 5'($urandom);
            branch_addr = $urandom; pc = $urandom;
            access(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), a, $urandom, got, exp);
            n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL rand_load it=%0d addr=%h got=%h exp=%h", it, a, got, exp);
            end
            n_cmp++;
            if (side_got() !== side_exp()) begin
                n_err++; $display("FAIL rand_passthru it=%0d got=%h exp=%h", it, side_got(), side_exp());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        test_reset();
        test_spec_sequence();
        test_branch();
        test_sign();
        test_wrap();
        test_read_during_write();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
